// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: RS-232 receiver with configurable word format, 3-sample majority
// voting, per-word error flags and a show-ahead valid/ready output FIFO.
module uart_rx_fifo #(
   parameter int unsigned ClkFrequency = 48000000,
   parameter int unsigned Baud         = 38400,
   parameter int unsigned Oversampling = 16,
   parameter int unsigned DataBits     = 8,
   parameter int unsigned ParityMode   = 0,
   parameter int unsigned FifoDepth    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                RxD,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [DataBits-1:0] m_data,
   output logic                m_parity_err,
   output logic                m_frame_err,
   output logic                m_break,
   output logic                overrun,
   output logic                rx_busy
);
   localparam logic [63:0] INC_L = (64'(Baud) * 64'(Oversampling) * 64'd65536
                                    + 64'(ClkFrequency / 2)) / 64'(ClkFrequency);
   localparam logic [15:0] INC    = 16'(INC_L);
   localparam int unsigned CNT_W  = $clog2(Oversampling);
   localparam int unsigned IDX_W  = $clog2(DataBits);
   localparam int unsigned PTR_W  = $clog2(FifoDepth);
   localparam int unsigned FCNT_W = PTR_W + 1;
   localparam int unsigned WORD_W = DataBits + 3;
   localparam logic [CNT_W-1:0]  SMP0     = CNT_W'(Oversampling / 2 - 1);
   localparam logic [CNT_W-1:0]  SMP1     = CNT_W'(Oversampling / 2);
   localparam logic [CNT_W-1:0]  VOTE     = CNT_W'(Oversampling / 2 + 1);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(Oversampling - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DataBits - 1);
   localparam logic [FCNT_W-1:0] FULL     = FCNT_W'(FifoDepth);
   localparam logic ODD     = (ParityMode == 32'd2);
   localparam logic HAS_PAR = (ParityMode != 32'd0);

   if (INC_L == 64'd0 || INC_L >= 64'd65536) begin : g_bad_inc
      $error("uart_rx_fifo: phase increment out of range for this Baud/ClkFrequency");
   end
   if (DataBits < 5 || DataBits > 9 || ParityMode > 2 || Oversampling < 8 ||
       Oversampling > 32 || (1 << CNT_W) != Oversampling ||
       FifoDepth < 2 || (1 << PTR_W) != FifoDepth) begin : g_bad_param
      $error("uart_rx_fifo: unsupported parameter combination");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_e;

   logic [15:0]         acc_q, acc_d;
   logic                tick_q, tick_d;
   logic                sync_q, sync_d, rx_s_q, rx_s_d;
   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DataBits-1:0] shift_q, shift_d;
   logic                s0_q, s0_d, s1_q, s1_d;
   logic                par_bit_q, par_bit_d, par_err_q, par_err_d;
   logic                push_q, push_d;
   logic [WORD_W-1:0]   push_word_q, push_word_d;
   logic [WORD_W-1:0]   mem_q [FifoDepth];
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [FCNT_W-1:0]   count_q, count_d;
   logic                m_valid_q, m_valid_d;
   logic [WORD_W-1:0]   head_q, head_d;
   logic                overrun_q, overrun_d;
   logic                rx_busy_q, rx_busy_d;
   logic                vote_c, vote_at_c, last_c, brk_c;
   logic                pop_c, push_ok_c;
   logic [FCNT_W-1:0]   remain_c;

   // Phase-accumulator tick generator and input synchroniser
   always_comb begin
      {tick_d, acc_d} = {1'b0, acc_q} + {1'b0, INC};
      sync_d = RxD;
      rx_s_d = sync_q;
   end

   // Receiver FSM: counts ticks within each bit and votes on the three middle samples
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      s0_d        = s0_q;
      s1_d        = s1_q;
      par_bit_d   = par_bit_q;
      par_err_d   = par_err_q;
      push_d      = 1'b0;
      push_word_d = push_word_q;
      vote_c      = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
      vote_at_c   = tick_q && (cnt_q == VOTE);
      last_c      = tick_q && (cnt_q == LAST_CNT);
      brk_c       = ~vote_c & (shift_q == '0) & ~par_bit_q;

      if (tick_q && state_q != IDLE && state_q != WAIT_HIGH) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == SMP0) s0_d = rx_s_q;
         if (cnt_q == SMP1) s1_d = rx_s_q;
      end

      case (state_q)
         IDLE: begin
            if (tick_q && !rx_s_q) begin
               state_d   = START;
               cnt_d     = '0;
               par_bit_d = 1'b0;
               par_err_d = 1'b0;
            end
         end
         START: begin
            if (vote_at_c && vote_c) begin
               state_d = IDLE;
            end else if (last_c) begin
               state_d = DATA;
               idx_d   = '0;
            end
         end
         DATA: begin
            if (vote_at_c) shift_d = {vote_c, shift_q[DataBits-1:1]};
            if (last_c) begin
               if (idx_q == LAST_IDX) state_d = HAS_PAR ? PARITY : STOP;
               else                   idx_d   = idx_q + IDX_W'(1);
            end
         end
         PARITY: begin
            if (vote_at_c) begin
               par_bit_d = vote_c;
               par_err_d = ((^shift_q) ^ vote_c) != ODD;
            end
            if (last_c) state_d = STOP;
         end
         STOP: begin
            // Leave at the vote rather than at end of bit to regain resync margin
            if (vote_at_c) begin
               push_d      = 1'b1;
               push_word_d = {brk_c, ~vote_c, par_err_q, shift_q};
               state_d     = vote_c ? IDLE : WAIT_HIGH;
            end
         end
         WAIT_HIGH: begin
            if (tick_q && rx_s_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      rx_busy_d = (state_d != IDLE);
   end

   // Show-ahead FIFO with registered head; a full FIFO still accepts when popped this cycle
   always_comb begin
      pop_c     = m_valid_q & m_ready;
      push_ok_c = push_q & ((count_q != FULL) | pop_c);
      overrun_d = push_q & ~push_ok_c;
      remain_c  = count_q - FCNT_W'(pop_c);
      count_d   = remain_c + FCNT_W'(push_ok_c);
      rd_ptr_d  = rd_ptr_q + PTR_W'(pop_c);
      wr_ptr_d  = wr_ptr_q + PTR_W'(push_ok_c);
      m_valid_d = (count_d != '0);
      head_d    = head_q;
      if (count_d != '0) begin
         if (remain_c == '0) head_d = push_word_q;
         else                head_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok_c) mem_q[wr_ptr_q] <= push_word_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q       <= '0;
         tick_q      <= 1'b0;
         sync_q      <= 1'b1;
         rx_s_q      <= 1'b1;
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         s0_q        <= 1'b1;
         s1_q        <= 1'b1;
         par_bit_q   <= 1'b0;
         par_err_q   <= 1'b0;
         push_q      <= 1'b0;
         push_word_q <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         m_valid_q   <= 1'b0;
         head_q      <= '0;
         overrun_q   <= 1'b0;
         rx_busy_q   <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         tick_q      <= tick_d;
         sync_q      <= sync_d;
         rx_s_q      <= rx_s_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         s0_q        <= s0_d;
         s1_q        <= s1_d;
         par_bit_q   <= par_bit_d;
         par_err_q   <= par_err_d;
         push_q      <= push_d;
         push_word_q <= push_word_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         m_valid_q   <= m_valid_d;
         head_q      <= head_d;
         overrun_q   <= overrun_d;
         rx_busy_q   <= rx_busy_d;
      end
   end

   assign m_valid = m_valid_q;
   assign {m_break, m_frame_err, m_parity_err, m_data} = head_q;
   assign overrun = overrun_q;
   assign rx_busy = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: three receivers (8N1, 7E1, 7O1) driven by a timed line model;
// expected words come from a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
   localparam int unsigned N     = 3;
   localparam int unsigned DEPTH = 4;
   localparam real CLK_NS = 62.5;
   localparam real BIT_NS = 10000.0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0]      rxd, m_ready, m_valid, pe, fe, brk, ovr, busy;
   logic [N-1:0][8:0] m_data;

   logic [11:0] exp_q [N][$];
   bit          hold_mode [N];
   int          exp_ovr [N];
   int          ovr_cnt [N];
   bit          ovr_prev [N];
   bit          hold_prev [N];
   logic [11:0] prev_word [N];
   logic [11:0] mon_act;
   logic [11:0] mon_exp;
   bit          rand_ready = 1'b0;
   int          n_checks = 0;
   int          n_pass = 0;

   always #(CLK_NS / 2.0) clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int unsigned DB = (g == 0) ? 8 : 7;
      logic [DB-1:0] data;
      uart_rx_fifo #(
         .ClkFrequency(16000000), .Baud(100000), .Oversampling(16),
         .DataBits(DB), .ParityMode(g), .FifoDepth(DEPTH)
      ) u_dut (
         .clk(clk), .rst(rst), .RxD(rxd[g]),
         .m_valid(m_valid[g]), .m_ready(m_ready[g]), .m_data(data),
         .m_parity_err(pe[g]), .m_frame_err(fe[g]), .m_break(brk[g]),
         .overrun(ovr[g]), .rx_busy(busy[g])
      );
      assign m_data[g] = 9'(data);
   end

   task automatic chk(input bit ok, input string name, input logic [11:0] act, input logic [11:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Frame-level reference: instance g has mode g (0 none, 1 even, 2 odd)
   function automatic logic [11:0] model(input int g, input logic [8:0] data, input bit pbit, input bit stop);
      int db;
      int ones;
      logic [8:0] d;
      bit p_err, f_err, b;
      db = (g == 0) ? 8 : 7;
      ones = 0;
      d = '0;
      for (int i = 0; i < db; i++) begin
         d[i] = data[i];
         ones += int'(data[i]);
      end
      p_err = (g != 0) && (((ones + int'(pbit)) % 2) != ((g == 2) ? 1 : 0));
      f_err = !stop;
      b     = f_err && (ones == 0) && (g == 0 || !pbit);
      return {b, f_err, p_err, d};
   endfunction

   task automatic push_exp(input int g, input logic [11:0] w);
      if (hold_mode[g] && exp_q[g].size() >= DEPTH) exp_ovr[g]++;
      else exp_q[g].push_back(w);
   endtask

   task automatic send_frame(input int g, input logic [8:0] data, input bit pbit, input bit stop, input real adj);
      real bt;
      int db;
      bt = BIT_NS / (1.0 + adj);
      db = (g == 0) ? 8 : 7;
      push_exp(g, model(g, data, pbit, stop));
      rxd[g] = 1'b0;
      #(bt);
      for (int i = 0; i < db; i++) begin
         rxd[g] = data[i];
         #(bt);
      end
      if (g != 0) begin
         rxd[g] = pbit;
         #(bt);
      end
      rxd[g] = stop;
      #(bt);
      rxd[g] = 1'b1;
   endtask

   task automatic idle(input real bits);
      #(bits * BIT_NS);
   endtask

   task automatic set_ready(input int g, input bit v);
      @(posedge clk);
      #2;
      m_ready[g] = v;
   endtask

   task automatic chk_reset(input int g);
      chk({m_valid[g], ovr[g], busy[g]} == 3'b000, "reset_ctrl",
          12'({m_valid[g], ovr[g], busy[g]}), 12'h000);
      chk({brk[g], fe[g], pe[g], m_data[g]} == 12'h000, "reset_word",
          {brk[g], fe[g], pe[g], m_data[g]}, 12'h000);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rand_ready) for (int g = 0; g < N; g++) m_ready[g] = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: pops the scoreboard on every handshake, checks hold stability and overrun width
   always @(negedge clk) begin
      for (int g = 0; g < N; g++) begin
         if (rst) begin
            hold_prev[g] = 1'b0;
            ovr_prev[g]  = 1'b0;
         end else begin
            mon_act = {brk[g], fe[g], pe[g], m_data[g]};
            if (ovr[g]) begin
               ovr_cnt[g]++;
               chk(!ovr_prev[g], "overrun_width", 12'(ovr_prev[g]), 12'h0);
            end
            ovr_prev[g] = ovr[g];
            if (hold_prev[g])
               chk(m_valid[g] && mon_act == prev_word[g], "hold_stable",
                   {3'b0, m_valid[g], mon_act[7:0]}, {4'b0001, prev_word[g][7:0]});
            if (m_valid[g] && m_ready[g]) begin
               if (exp_q[g].size() == 0) begin
                  chk(1'b0, "unexpected_word", mon_act, 12'h000);
               end else begin
                  mon_exp = exp_q[g].pop_front();
                  chk(mon_act == mon_exp, "word", mon_act, mon_exp);
               end
            end
            hold_prev[g] = m_valid[g] && !m_ready[g];
            prev_word[g] = mon_act;
         end
      end
   end

   initial begin
      #(98000.0 * CLK_NS);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog");
   end

   initial begin
      rxd = '1;
      m_ready = '1;
      for (int g = 0; g < N; g++) begin
         hold_mode[g] = 1'b0;
         exp_ovr[g] = 0;
         ovr_cnt[g] = 0;
      end
      #200;
      for (int g = 0; g < N; g++) chk_reset(g);
      @(negedge clk);
      rst = 1'b0;
      idle(2);

      send_frame(0, 9'h0A5, 1'b0, 1'b1, 0.0);
      send_frame(0, 9'h03C, 1'b0, 1'b1, 0.0);
      idle(2);

      for (int g = 1; g < N; g++) begin
         send_frame(g, 9'h055, 1'b1, 1'b1, 0.0);
         idle(1);
         send_frame(g, 9'h055, 1'b0, 1'b1, 0.0);
         idle(1);
      end

      send_frame(0, 9'h041, 1'b0, 1'b0, 0.0);
      idle(1);
      push_exp(0, model(0, 9'h000, 1'b0, 1'b0));
      rxd[0] = 1'b0;
      idle(30);
      rxd[0] = 1'b1;
      idle(2);
      send_frame(0, 9'h012, 1'b0, 1'b1, 0.0);
      idle(2);

      set_ready(0, 1'b0);
      hold_mode[0] = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         send_frame(0, 9'(i), 1'b0, 1'b1, 0.0);
         idle(1);
      end
      hold_mode[0] = 1'b0;
      chk(ovr_cnt[0] == exp_ovr[0], "overrun_count", 12'(ovr_cnt[0]), 12'(exp_ovr[0]));
      set_ready(0, 1'b1);
      idle(1);

      rxd[0] = 1'b0;
      #(3.0 * CLK_NS);
      rxd[0] = 1'b1;
      idle(2);
      chk(busy[0] == 1'b0, "glitch_idle", 12'(busy[0]), 12'h0);

      for (int s = 0; s < 2; s++) begin
         real adj;
         adj = (s == 0) ? 0.03 : -0.03;
         send_frame(0, 9'h0FF, 1'b0, 1'b1, adj);
         idle(1);
         send_frame(0, 9'h000, 1'b0, 1'b1, adj);
         idle(1);
         send_frame(0, 9'h080, 1'b0, 1'b1, adj);
         idle(1);
      end
      idle(1);

      fork
         send_frame(0, 9'h0C3, 1'b0, 1'b1, 0.0);
         begin
            idle(5.5);
            chk(busy[0] == 1'b1, "busy_midframe", 12'(busy[0]), 12'h1);
            rst = 1'b1;
            #1;
            chk_reset(0);
         end
      join
      exp_q[0].delete();
      idle(1);
      @(negedge clk);
      rst = 1'b0;
      idle(1);
      send_frame(0, 9'h099, 1'b0, 1'b1, 0.0);
      idle(2);

      rand_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         int g;
         g = $urandom_range(0, N - 1);
         send_frame(g, 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 7) != 0, (real'($urandom_range(0, 60)) - 30.0) / 1000.0);
         idle(1);
      end
      rand_ready = 1'b0;
      for (int g = 0; g < N; g++) set_ready(g, 1'b1);
      idle(2);

      for (int g = 0; g < N; g++)
         chk(exp_q[g].size() == 0, "missing_words", 12'(exp_q[g].size()), 12'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
